la_cmd_master: RTL and testbench
================================

Name: la_cmd_master

Overview:
- Initiator side of the logic-analyzer command protocol that the LA-controlled user projects respond to.
- Accepts a start request with two operands and issues the command sequence on the 32-bit LA command word (maps to la_data_in[63:32]): enter-write, write A, write B, go.
- Then waits for the responder's result marker on the 128-bit response bus, captures the result and reports it.
- Used by on-chip self-test, and as a reusable stimulus master in the harness, in place of firmware bit-banging.

Parameters:
- BITS, 16, operand/result width; 1..64.
- HOLD, 2, cycles each command word is held on la_cmd_out; >=1.
- TIMEOUT, 4095, max cycles in WAIT states before abort; >=1.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- op_a  in  BITS  operand A, sampled when start is accepted.
- op_b  in  BITS  operand B, sampled when start is accepted.
- la_resp_in  in  128  responder's la_data_out.
- la_cmd_out  out  32  [31:16] command code, [15:0] data (zero-extended operand).
- la_cmd_oenb  out  1  0 while driving a sequence, 1 in IDLE (replicated onto la_oenb[63:32] by the wrapper).
- busy  out  1  high in every state except IDLE.
- result  out  BITS  last captured result; holds until the next capture.
- result_valid  out  1  one-cycle pulse on capture.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (async assert, sync release): state=IDLE; la_cmd_out=0; la_cmd_oenb=1; busy=0; result=0; result_valid=0; timeout_err=0; hold and timeout counters=0.
- Command codes: ENTER=16'hAB00, WR_A=16'hA000, WR_B=16'hA001, GO=16'hAB40, NOP=16'h0000.
- States: IDLE, ENTER, WR_A, WR_B, GO, WAIT_CLR, WAIT_SET, DONE.
- IDLE: la_cmd_out={NOP,16'h0}.
  - start=1: latch op_a/op_b, go to ENTER.
  - start=0 ignored.
  - start while busy: ignored, never queued.
- ENTER/WR_A/WR_B/GO: each drives its word for exactly HOLD cycles, then advances to the next state in that order.
  - ENTER data=0; WR_A data=latched A; WR_B data=latched B; GO data=0.
  - Word changes on the clock edge entering the state (registered output).
- After GO: la_cmd_out={NOP,0}, la_cmd_oenb stays 0, go to WAIT_CLR.
- Marker: la_resp_in[127:BITS] all ones.
- WAIT_CLR: wait for marker=0. This rejects a stale marker left by a previous transaction before the responder clears its output.
- WAIT_SET: wait for marker=1. On the first marked cycle, result<=la_resp_in[BITS-1:0], go to DONE.
- DONE (1 cycle): result_valid=1, then IDLE. busy stays high in DONE.
- Timeout: the counter resets on entry to WAIT_CLR and keeps counting across WAIT_CLR and WAIT_SET.
  - If it reaches TIMEOUT with no capture: timeout_err pulses 1 cycle, result unchanged, go to IDLE.
- Reset mid-sequence: immediate return to the reset values; no partial result.
- Minimum latency with responder marker clear at GO exit and set k cycles later: start accepted at cycle 0 -> result_valid at cycle 4*HOLD+k+2.

Test Plan:
- Basic: HOLD=2, op_a=16'h0005, op_b=16'h0009, start pulse -> la_cmd_out exactly AB000000 x2, A0000005 x2, A0010009 x2, AB400000 x2, then 0. Model responder asserts {112'hFF..F,16'h03E8} after 20 cycles -> result=16'h03E8, result_valid 1 cycle, busy falls the cycle after.
- Stale marker: la_resp_in already marked with 16'h1234 before start, cleared 3 cycles after GO, re-marked with 16'h0042 -> result=16'h0042, never 16'h1234.
- Timeout: TIMEOUT=50, responder never marks -> timeout_err pulses 50 cycles after WAIT_CLR entry, result keeps its prior value, returns to IDLE, la_cmd_oenb=1.
- Start while busy: second start pulses during WR_B and WAIT_SET -> ignored; exactly one command sequence and one result_valid.
- Async reset: assert wb_rst_n low in the middle of WR_A (not on a clock edge) -> outputs reach reset values immediately; a fresh start after release runs a full correct sequence.
- Back-to-back: start held high through DONE -> new sequence begins from IDLE with newly sampled operands; two result_valid pulses with the correct, distinct results.

Source files
------------

// File: rtl/la_cmd_master.sv
// LA command initiator: issues ENTER/WR_A/WR_B/GO words, then waits for a fresh result marker and captures it.
// Latency 4*HOLD + k + 2 cycles from start to result_valid; start is ignored while busy, so there is no queueing or backpressure.
module la_cmd_master #(
  parameter int BITS    = 16,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,
  input  logic            start,
  input  logic [BITS-1:0] op_a,
  input  logic [BITS-1:0] op_b,
  input  logic [127:0]    la_resp_in,
  output logic [31:0]     la_cmd_out,
  output logic            la_cmd_oenb,
  output logic            busy,
  output logic [BITS-1:0] result,
  output logic            result_valid,
  output logic            timeout_err
);

  localparam logic [15:0] CODE_ENTER = 16'hAB00;
  localparam logic [15:0] CODE_WR_A  = 16'hA000;
  localparam logic [15:0] CODE_WR_B  = 16'hA001;
  localparam logic [15:0] CODE_GO    = 16'hAB40;

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER, S_WR_A, S_WR_B, S_GO, S_WAIT_CLR, S_WAIT_SET, S_DONE
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [BITS-1:0] a_q;
  logic [BITS-1:0] b_q;
  logic            marker;

  assign marker = &la_resp_in[127:BITS];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      tmo_cnt      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      la_cmd_out   <= '0;
      la_cmd_oenb  <= 1'b1;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q         <= op_a;
            b_q         <= op_b;
            hold_cnt    <= '0;
            state       <= S_ENTER;
            la_cmd_out  <= {CODE_ENTER, 16'h0000};
            la_cmd_oenb <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_ENTER, S_WR_A, S_WR_B, S_GO: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            case (state)
              S_ENTER: begin
                state      <= S_WR_A;
                la_cmd_out <= {CODE_WR_A, 16'(a_q)};
              end
              S_WR_A: begin
                state      <= S_WR_B;
                la_cmd_out <= {CODE_WR_B, 16'(b_q)};
              end
              S_WR_B: begin
                state      <= S_GO;
                la_cmd_out <= {CODE_GO, 16'h0000};
              end
              default: begin
                state      <= S_WAIT_CLR;
                la_cmd_out <= '0;
                tmo_cnt    <= '0;
              end
            endcase
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_WAIT_CLR, S_WAIT_SET: begin
          // One timeout window spans both wait states; a capture on the last cycle still wins.
          if (state == S_WAIT_SET && marker) begin
            result       <= la_resp_in[BITS-1:0];
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
            busy        <= 1'b0;
            la_cmd_oenb <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (state == S_WAIT_CLR && !marker) state <= S_WAIT_SET;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          la_cmd_oenb <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_la_cmd_master.sv
// Bench for la_cmd_master: transaction-level model with per-cycle compare, directed scenarios and random traffic.
module tb_la_cmd_master;
  localparam int BITS = 16;
  localparam int HOLD = 2;
  localparam int TIMEOUT = 50;
  localparam int PH_IDLE = 0, PH_SEQ = 1, PH_WAIT = 2, PH_DONE = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  op_a = '0;
  logic [15:0]  op_b = '0;
  logic [127:0] resp = '0;
  logic [31:0]  la_cmd_out;
  logic         la_cmd_oenb, busy, result_valid, timeout_err;
  logic [15:0]  result;

  la_cmd_master #(.BITS(BITS), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .la_resp_in(resp), .la_cmd_out(la_cmd_out), .la_cmd_oenb(la_cmd_oenb),
    .busy(busy), .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Transaction-level model: a queue of command words, then a wait window
  int          m_phase;
  logic [31:0] exp_cmd;
  logic        exp_oenb, exp_busy, exp_rv, exp_te;
  logic [15:0] exp_res;
  logic [31:0] cmd_q[$];
  int          wait_i;
  bit          seen_clear;

  function automatic bit is_marked(input logic [127:0] r);
    return &r[127:BITS];
  endfunction

  function automatic void load_words(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] words[4];
    words[0] = {16'hAB00, 16'h0000};
    words[1] = {16'hA000, a};
    words[2] = {16'hA001, b};
    words[3] = {16'hAB40, 16'h0000};
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < HOLD; i++) cmd_q.push_back(words[w]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_IDLE; exp_cmd <= '0; exp_oenb <= 1'b1; exp_busy <= 1'b0;
      exp_res <= '0; exp_rv <= 1'b0; exp_te <= 1'b0; wait_i <= 0; seen_clear <= 1'b0;
      cmd_q.delete();
    end else begin
      exp_rv <= 1'b0;
      exp_te <= 1'b0;
      case (m_phase)
        PH_IDLE: if (start) begin
          load_words(op_a, op_b);
          exp_cmd <= cmd_q.pop_front();
          exp_oenb <= 1'b0; exp_busy <= 1'b1; m_phase <= PH_SEQ;
        end
        PH_SEQ: if (cmd_q.size() > 0) exp_cmd <= cmd_q.pop_front();
                else begin
                  exp_cmd <= '0; m_phase <= PH_WAIT; wait_i <= 0; seen_clear <= 1'b0;
                end
        PH_WAIT: begin
          if (seen_clear && is_marked(resp)) begin
            exp_res <= resp[15:0]; exp_rv <= 1'b1; m_phase <= PH_DONE;
          end else if (wait_i == TIMEOUT - 1) begin
            exp_te <= 1'b1; exp_busy <= 1'b0; exp_oenb <= 1'b1; m_phase <= PH_IDLE;
          end else begin
            wait_i <= wait_i + 1;
            if (!is_marked(resp)) seen_clear <= 1'b1;
          end
        end
        default: begin
          m_phase <= PH_IDLE; exp_busy <= 1'b0; exp_oenb <= 1'b1;
        end
      endcase
    end
  end

  logic [31:0] prev_cmd = '0, last_wr_a = '0, last_wr_b = '0;
  int enter_cnt = 0, rv_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd", 128'(la_cmd_out), 128'(exp_cmd));
      chk("oenb", 128'(la_cmd_oenb), 128'(exp_oenb));
      chk("busy", 128'(busy), 128'(exp_busy));
      chk("result", 128'(result), 128'(exp_res));
      chk("result_valid", 128'(result_valid), 128'(exp_rv));
      chk("timeout_err", 128'(timeout_err), 128'(exp_te));
      if (la_cmd_out == 32'hAB000000 && prev_cmd != 32'hAB000000) enter_cnt <= enter_cnt + 1;
      if (la_cmd_out[31:16] == 16'hA000) last_wr_a <= la_cmd_out;
      if (la_cmd_out[31:16] == 16'hA001) last_wr_b <= la_cmd_out;
      if (result_valid) rv_cnt <= rv_cnt + 1;
      prev_cmd <= la_cmd_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int ph, input string nm);
    int i;
    i = 0;
    while (m_phase != ph && i < 300) begin
      step();
      i++;
    end
    if (m_phase != ph) bound_fail(nm);
  endtask

  task automatic wait_rv_chk(input string nm, input logic [15:0] want);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) ok = 1'b1;
    end
    if (ok) chk(nm, 128'(result), 128'(want));
    else bound_fail(nm);
  endtask

  function automatic logic [127:0] mark(input logic [15:0] v);
    return {{112{1'b1}}, v};
  endfunction

  initial begin
    logic [31:0] cmd_log[9];
    logic [31:0] cmd_exp[9];
    int ec0, rc0, last_go, te_at, cd, sd, h;
    bit found, never;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd", 128'(la_cmd_out), 128'(0));
    chk("rst_oenb", 128'(la_cmd_oenb), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_result", 128'(result), 128'(0));
    step();

    // Basic sequence with literal command words
    resp = '0; op_a = 16'h0005; op_b = 16'h0009; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cmd_log[i] = la_cmd_out;
    end
    cmd_exp = '{32'hAB000000, 32'hAB000000, 32'hA0000005, 32'hA0000005,
                32'hA0010009, 32'hA0010009, 32'hAB400000, 32'hAB400000, 32'h0};
    for (int i = 0; i < 9; i++) chk($sformatf("basic_word%0d", i), 128'(cmd_log[i]), 128'(cmd_exp[i]));
    repeat (20) step();
    resp = mark(16'h03E8);
    wait_rv_chk("basic_result", 16'h03E8);
    @(negedge clk);
    chk("basic_busy_after", 128'(busy), 128'(0));

    // Stale marker must be skipped
    step();
    resp = mark(16'h1234); op_a = 16'h0007; op_b = 16'h0003; start = 1'b1;
    step();
    start = 1'b0;
    wait_phase(PH_WAIT, "stale_wait");
    repeat (3) step();
    resp = '0;
    repeat (2) step();
    resp = mark(16'h0042);
    wait_rv_chk("stale_result", 16'h0042);

    // Timeout with no marker
    step();
    resp = '0; op_a = 16'hBEEF; op_b = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    last_go = -1; te_at = -1;
    for (int n = 0; n < 300 && te_at < 0; n++) begin
      @(negedge clk);
      if (la_cmd_out[31:16] == 16'hAB40) last_go = n;
      if (timeout_err === 1'b1) begin
        te_at = n;
        chk("tmo_oenb", 128'(la_cmd_oenb), 128'(1));
        chk("tmo_busy", 128'(busy), 128'(0));
        chk("tmo_result_kept", 128'(result), 128'(16'h0042));
      end
    end
    if (te_at < 0) bound_fail("tmo_pulse");
    else chk("tmo_delay", 128'(te_at - (last_go + 1)), 128'(TIMEOUT));

    // Start pulses while busy are dropped
    step();
    ec0 = enter_cnt; rc0 = rv_cnt;
    resp = '0; op_a = 16'h0011; op_b = 16'h0022; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (exp_cmd[31:16] == 16'hA001) begin start = 1'b1; found = 1'b1; end
      step();
    end
    start = 1'b0;
    if (!found) bound_fail("busy_wr_b");
    wait_phase(PH_WAIT, "busy_wait");
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (seen_clear) found = 1'b1;
      else step();
    end
    if (!found) bound_fail("busy_wait_set");
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    resp = mark(16'h0BEE);
    wait_rv_chk("busy_result", 16'h0BEE);
    repeat (6) step();
    chk("busy_one_sequence", 128'(enter_cnt - ec0), 128'(1));
    chk("busy_one_result", 128'(rv_cnt - rc0), 128'(1));

    // Back-to-back with start held high
    op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;
    wait_phase(PH_WAIT, "b2b_wait1");
    op_a = 16'h3333; op_b = 16'h4444; resp = '0;
    repeat (2) step();
    resp = mark(16'h0AAA);
    wait_rv_chk("b2b_result1", 16'h0AAA);
    step();
    wait_phase(PH_SEQ, "b2b_restart");
    start = 1'b0;
    wait_phase(PH_WAIT, "b2b_wait2");
    chk("b2b_wr_a", 128'(last_wr_a), 128'(32'hA0003333));
    chk("b2b_wr_b", 128'(last_wr_b), 128'(32'hA0014444));
    resp = '0;
    repeat (2) step();
    resp = mark(16'h0BBB);
    wait_rv_chk("b2b_result2", 16'h0BBB);

    // Asynchronous reset in the middle of WR_A
    step();
    op_a = 16'h0005; op_b = 16'h0006; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (exp_cmd[31:16] == 16'hA000) found = 1'b1;
      else step();
    end
    if (!found) bound_fail("arst_wr_a");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd", 128'(la_cmd_out), 128'(0));
    chk("arst_oenb", 128'(la_cmd_oenb), 128'(1));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_result", 128'(result), 128'(0));
    chk("arst_rv", 128'(result_valid), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    resp = '0; op_a = 16'h00C3; op_b = 16'h003C; start = 1'b1;
    step();
    start = 1'b0;
    wait_phase(PH_WAIT, "arst_wait");
    repeat (3) step();
    resp = mark(16'h5A5A);
    wait_rv_chk("arst_fresh_result", 16'h5A5A);

    // Random traffic against the model
    for (int t = 0; t < 30; t++) begin
      step();
      cd = $urandom_range(0, 4);
      sd = $urandom_range(1, 10);
      h = $urandom_range(1, 3);
      never = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) resp = mark(16'($urandom));
      else begin
        resp = {$urandom, $urandom, $urandom, $urandom};
        resp[127] = 1'b0;
      end
      op_a = 16'($urandom); op_b = 16'($urandom); start = 1'b1;
      repeat (h) step();
      start = 1'b0;
      wait_phase(PH_WAIT, "rand_wait");
      repeat (cd) step();
      resp = {1'b0, 31'($urandom), $urandom, $urandom, $urandom};
      repeat (sd) step();
      if (!never) resp = mark(16'($urandom));
      wait_phase(PH_IDLE, "rand_idle");
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
